// File: rtl/pipeline_ctrl_pkg.sv
// Shared definitions for the pipeline sequencing logic.
// Holds the controller state encoding, the NOP instruction loaded by the pipeline registers on a
// flush or bubble, the default register-index width and the control-output bundle with helpers
// for its two common settings (normal and freeze).
package pipeline_ctrl_pkg;

    localparam int unsigned REG_ADDR_W = 5;

    // addi x0, x0, 0
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    localparam logic [1:0] RUN      = 2'd0;
    localparam logic [1:0] MEM_WAIT = 2'd1;
    localparam logic [1:0] HALT     = 2'd2;

    typedef enum logic [1:0] {
        StRun     = RUN,
        StMemWait = MEM_WAIT,
        StHalt    = HALT
    } ctrl_state_e;

    typedef struct packed {
        logic pc_write;
        logic ifid_write;
        logic ifid_flush;
        logic idex_bubble;
        logic stage_hold;
        logic memwb_bubble;
        logic halted;
    } ctrl_out_t;

    function automatic ctrl_out_t normal_set();
        ctrl_out_t c;
        c            = '0;
        c.pc_write   = 1'b1;
        c.ifid_write = 1'b1;
        return c;
    endfunction

    // Whole pipeline held; MEM/WB drains a NOP so WB never retires the stalled access twice.
    function automatic ctrl_out_t freeze_set();
        ctrl_out_t c;
        c              = '0;
        c.stage_hold   = 1'b1;
        c.memwb_bubble = 1'b1;
        return c;
    endfunction

endpackage

// File: rtl/pipeline_hazard_controller_if.sv
// Signal bundle between the pipeline datapath and the hazard controller.
// slave  : used by the controller (reads ID/EX/MEM status, drives pipeline control).
// master : used by the datapath or a testbench (drives status, reads control).
interface pipeline_hazard_controller_if #(
    parameter int unsigned REG_ADDR_W  = 5,
    parameter int unsigned STALL_CNT_W = 16
);
    logic [REG_ADDR_W-1:0]  id_rs1_i;
    logic [REG_ADDR_W-1:0]  id_rs2_i;
    logic                   id_uses_rs1_i;
    logic                   id_uses_rs2_i;
    logic [REG_ADDR_W-1:0]  ex_rd_i;
    logic                   ex_mem_read_i;
    logic                   ex_branch_taken_i;
    logic                   mem_req_i;
    logic                   mem_ready_i;
    logic                   pc_write_o;
    logic                   ifid_write_o;
    logic                   ifid_flush_o;
    logic                   idex_bubble_o;
    logic                   stage_hold_o;
    logic                   memwb_bubble_o;
    logic                   halted_o;
    logic [STALL_CNT_W-1:0] stall_count_o;

    modport slave (
        input  id_rs1_i, id_rs2_i, id_uses_rs1_i, id_uses_rs2_i, ex_rd_i, ex_mem_read_i,
               ex_branch_taken_i, mem_req_i, mem_ready_i,
        output pc_write_o, ifid_write_o, ifid_flush_o, idex_bubble_o, stage_hold_o,
               memwb_bubble_o, halted_o, stall_count_o
    );

    modport master (
        output id_rs1_i, id_rs2_i, id_uses_rs1_i, id_uses_rs2_i, ex_rd_i, ex_mem_read_i,
               ex_branch_taken_i, mem_req_i, mem_ready_i,
        input  pc_write_o, ifid_write_o, ifid_flush_o, idex_bubble_o, stage_hold_o,
               memwb_bubble_o, halted_o, stall_count_o
    );
endinterface

// File: rtl/load_use_detector.sv
// Combinational load-use hazard compare.
// Flags when the load in EX writes a register that the instruction in ID actually reads.
// x0 is never a hazard since writes to it are discarded.
// Ports: rs1/rs2/uses_rs1/uses_rs2 (ID operands), ex_rd/ex_mem_read (EX load), hazard (flag).
module load_use_detector #(
    parameter int unsigned REG_ADDR_W = 5
) (
    input  logic [REG_ADDR_W-1:0] rs1,
    input  logic [REG_ADDR_W-1:0] rs2,
    input  logic                  uses_rs1,
    input  logic                  uses_rs2,
    input  logic [REG_ADDR_W-1:0] ex_rd,
    input  logic                  ex_mem_read,
    output logic                  hazard
);
    always_comb begin
        hazard = ex_mem_read && (ex_rd != '0) &&
                 ((uses_rs1 && (rs1 == ex_rd)) || (uses_rs2 && (rs2 == ex_rd)));
    end
endmodule

// File: rtl/pipeline_hazard_controller.sv
// Central sequencing block for the 5-stage pipeline.
// Stalls on load-use, flushes on taken branches, freezes while data memory is not ready and
// halts the core after MEM_TIMEOUT wait cycles. Outputs are Mealy (state + current inputs).
// Ports: clk, reset (synchronous, active-high), bus (slave modport of
// pipeline_hazard_controller_if carrying ID/EX/MEM status in and pipeline control out).
// Build option: HAZARD_STALL_PERF_EN adds the saturating stall-cycle counter on stall_count_o;
// without it stall_count_o is tied to zero.
module pipeline_hazard_controller
    import pipeline_ctrl_pkg::*;
#(
    parameter int unsigned REG_ADDR_W  = pipeline_ctrl_pkg::REG_ADDR_W,
    parameter int unsigned MEM_TIMEOUT = 15,
    parameter int unsigned STALL_CNT_W = 16
) (
    input logic                         clk,
    input logic                         reset,
    pipeline_hazard_controller_if.slave bus
);
    ctrl_state_e state_q, state_d;
    logic [7:0]  wait_cnt_q, wait_cnt_d;
    ctrl_out_t   ctrl;
    ctrl_out_t   run_ctrl;
    logic        load_use;

    load_use_detector #(
        .REG_ADDR_W (REG_ADDR_W)
    ) u_load_use_detector (
        .rs1         (bus.id_rs1_i),
        .rs2         (bus.id_rs2_i),
        .uses_rs1    (bus.id_uses_rs1_i),
        .uses_rs2    (bus.id_uses_rs2_i),
        .ex_rd       (bus.ex_rd_i),
        .ex_mem_read (bus.ex_mem_read_i),
        .hazard      (load_use)
    );

    // Branch/load-use/normal decision, shared by RUN and by MEM_WAIT on release since EX and ID
    // were held and still carry the same instructions.
    always_comb begin
        run_ctrl = normal_set();
        if (bus.ex_branch_taken_i) begin
            // ID instruction is killed, so any load-use against it is moot.
            run_ctrl.ifid_flush  = 1'b1;
            run_ctrl.idex_bubble = 1'b1;
        end else if (load_use) begin
            run_ctrl.pc_write    = 1'b0;
            run_ctrl.ifid_write  = 1'b0;
            run_ctrl.idex_bubble = 1'b1;
        end
    end

    always_comb begin
        ctrl       = normal_set();
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        if (!reset) begin
            case (state_q)
                StRun: begin
                    if (bus.mem_req_i && !bus.mem_ready_i) begin
                        ctrl       = freeze_set();
                        state_d    = StMemWait;
                        wait_cnt_d = 8'd1;
                    end else begin
                        ctrl = run_ctrl;
                    end
                end
                StMemWait: begin
                    if (bus.mem_ready_i) begin
                        ctrl       = run_ctrl;
                        state_d    = StRun;
                        wait_cnt_d = 8'd0;
                    end else begin
                        ctrl       = freeze_set();
                        wait_cnt_d = wait_cnt_q + 8'd1;
                        if (wait_cnt_q == 8'(MEM_TIMEOUT)) begin
                            state_d = StHalt;
                        end
                    end
                end
                StHalt: begin
                    ctrl        = freeze_set();
                    ctrl.halted = 1'b1;
                end
                default: begin
                    state_d    = StRun;
                    wait_cnt_d = 8'd0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StRun;
            wait_cnt_q <= 8'd0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
        end
    end

    assign bus.pc_write_o     = ctrl.pc_write;
    assign bus.ifid_write_o   = ctrl.ifid_write;
    assign bus.ifid_flush_o   = ctrl.ifid_flush;
    assign bus.idex_bubble_o  = ctrl.idex_bubble;
    assign bus.stage_hold_o   = ctrl.stage_hold;
    assign bus.memwb_bubble_o = ctrl.memwb_bubble;
    assign bus.halted_o       = ctrl.halted;

`ifdef HAZARD_STALL_PERF_EN
    logic [STALL_CNT_W-1:0] stall_count_q;

    // Saturates rather than wrapping so a long halt cannot look like a short run.
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_count_q <= '0;
        end else if (!ctrl.pc_write && (stall_count_q != '1)) begin
            stall_count_q <= stall_count_q + 1'b1;
        end
    end

    assign bus.stall_count_o = stall_count_q;
`else
    assign bus.stall_count_o = '0;
`endif

endmodule

// File: doc/pipeline_hazard_controller.md
Name: pipeline_hazard_controller

Overview:
- Central sequencing block for the 5-stage RISC-V pipeline (IF/ID/EX/MEM/WB).
- Resolves load-use hazards by stalling IF/ID and bubbling ID/EX.
- Flushes wrong-path instructions on a taken branch.
- Freezes the whole pipeline while data memory holds off with a ready handshake; a timeout watchdog halts the core if memory never answers.

Parameters:
REG_ADDR_W, 5, register-index width
MEM_TIMEOUT, 15, max consecutive MEM_WAIT cycles before HALT (1..255)
STALL_CNT_W, 16, width of the stall performance counter

Ports:
clk  in  1  clock, all state updates on rising edge
reset  in  1  synchronous, active-high
id_rs1_i  in  REG_ADDR_W  rs1 of instruction in ID (IF/ID register)
id_rs2_i  in  REG_ADDR_W  rs2 of instruction in ID
id_uses_rs1_i  in  1  ID instruction reads rs1
id_uses_rs2_i  in  1  ID instruction reads rs2
ex_rd_i  in  REG_ADDR_W  destination register of instruction in EX
ex_mem_read_i  in  1  EX instruction is a load
ex_branch_taken_i  in  1  EX resolved a taken branch/jump
mem_req_i  in  1  MEM stage performing a data-memory access
mem_ready_i  in  1  data memory completes access this cycle
pc_write_o  out  1  PC may update
ifid_write_o  out  1  IF/ID may load
ifid_flush_o  out  1  IF/ID loads NOP
idex_bubble_o  out  1  ID/EX loads NOP (control bits zero)
stage_hold_o  out  1  ID/EX, EX/MEM hold contents
memwb_bubble_o  out  1  MEM/WB loads NOP
halted_o  out  1  core in HALT
stall_count_o  out  STALL_CNT_W  stall cycles seen

Behaviour:
- States: RUN, MEM_WAIT, HALT (2-bit register).
- Outputs are combinational from state and inputs (Mealy); zero added latency.
- "Normal" output set: pc_write=1, ifid_write=1, all others 0.
- "Freeze" output set: pc_write=0, ifid_write=0, stage_hold=1, memwb_bubble=1, ifid_flush=0, idex_bubble=0.
- Reset (sampled high at edge):
  - state<=RUN, wait_cnt<=0, stall_count<=0, halted<=0.
  - While reset is high, outputs take the normal set.
- RUN, priority high to low:
  1. mem_req_i && !mem_ready_i: freeze set; next state MEM_WAIT; wait_cnt<=1.
  2. ex_branch_taken_i: ifid_flush=1, idex_bubble=1, pc_write=1, ifid_write=1. Load-use is ignored because the ID instruction is killed.
  3. Load-use: ex_mem_read_i && ex_rd_i!=0 && ((id_uses_rs1_i && id_rs1_i==ex_rd_i) || (id_uses_rs2_i && id_rs2_i==ex_rd_i)). Outputs: pc_write=0, ifid_write=0, idex_bubble=1. Exactly one cycle per occurrence, because the load leaves EX next cycle.
  4. Otherwise: normal set.
- MEM_WAIT:
  - mem_ready_i=0: freeze set; wait_cnt++. If wait_cnt==MEM_TIMEOUT, next state HALT.
  - mem_ready_i=1: evaluate exactly as RUN rules 2–4 (EX/ID contents were held, so a branch or hazard still applies); next state RUN; wait_cnt<=0.
  - mem_ready_i=1 in the same cycle the timeout would fire: ready wins, go to RUN.
- HALT: freeze set; halted_o=1; only reset exits.
- rd==x0 never causes a stall. mem_ready_i while mem_req_i=0 is ignored.
- stall_count increments by 1 in every cycle where pc_write_o==0 (load-use, MEM_WAIT entry/wait, HALT). It saturates at all-ones and does not wrap.

Optional Feature:
- Macro: HAZARD_STALL_PERF_EN.
- Defined: stall_count_o counter present as described.
- Undefined: counter logic not built; stall_count_o tied to 0.

Decomposition:
- Shared package `pipeline_ctrl_pkg`:
  - state encoding constants RUN=2'd0, MEM_WAIT=2'd1, HALT=2'd2;
  - NOP instruction constant 32'h0000_0013 (used by the pipeline registers on flush/bubble);
  - REG_ADDR_W default.
- One natural sub-module, `load_use_detector`: pure combinational rule-3 compare, reusable by a future forwarding unit.

Test Plan:
- Reset with all inputs 0 → pc_write=1, ifid_write=1, others 0, stall_count=0, halted=0.
- ex_mem_read=1, ex_rd=5, id_rs2=5, id_uses_rs2=1 for one cycle → pc_write=0, ifid_write=0, idex_bubble=1 that cycle; normal next cycle; stall_count=1. Repeat with ex_rd=0 → no stall.
- Same cycle: ex_branch_taken=1 and load-use match on rs1=7 → ifid_flush=1, idex_bubble=1, pc_write=1; stall_count unchanged.
- mem_req=1, mem_ready=0 for 3 cycles then ready=1 with ex_branch_taken=1 → freeze 3 cycles, then flush cycle; state back to RUN; stall_count=3.
- mem_req=1, mem_ready=0 held for 20 cycles (MEM_TIMEOUT=15) → HALT entered after 15 wait cycles; halted_o=1 and freeze persist despite later ready=1; reset returns to RUN with counters 0.
- Counter saturation with STALL_CNT_W=4: 20 stall cycles → stall_count_o=15. Build without HAZARD_STALL_PERF_EN → stall_count_o=0 throughout.
